// File: rtl/hr_step_pkg.sv
// Shared constants, sample record and saturating helper for the heart-rate /
// step sampler front-end.
package hr_step_pkg;

  localparam int BPM_SCALE  = 15;   // 4-window beat sum -> beats per minute
  localparam int HIST_DEPTH = 4;    // windows in the rolling heart-rate estimate
  localparam int CNT_W      = 3;    // per-window pulse counter width
  localparam int STEP_MAX   = 3;    // largest reportable steps per second
  localparam int BPM_MAX    = 255;  // largest reportable BPM

  localparam int SUM_W      = 5;    // 4 x 7 = 28 fits in 5 bits
  localparam int PROD_W     = 9;    // 15 x 28 = 420 fits in 9 bits
  localparam int HR_W       = 8;
  localparam int STEPS_W    = 2;
  localparam int STRIDE_W   = 8;

  typedef struct packed {
    logic [HR_W-1:0]     hr;
    logic [STEPS_W-1:0]  steps;
    logic [STRIDE_W-1:0] stride;
  } sample_t;

  // Increment a pulse counter, sticking at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                input logic inc);
    if (inc && (value != {CNT_W{1'b1}}))
      return value + CNT_W'(1);
    return value;
  endfunction

endpackage

// File: rtl/hr_step_sampler_pulse_conditioner.sv
// Conditions one asynchronous sensor level: two-flop synchronizer, level
// debounce, and a one-cycle pulse on each accepted rising level.
module pulse_conditioner #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic edge_pulse
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          edge_reg;
  logic [CW-1:0] cnt_reg;

  // Bring the raw level into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Accept a new level after DEBOUNCE consecutive differing cycles; the edge
  // pulse is registered together with the level so it lines up exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg <= 1'b0;
      edge_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      edge_reg <= 1'b0;
      if (sync2_reg != level_reg) begin
        if (cnt_reg == CNT_LAST) begin
          level_reg <= sync2_reg;
          edge_reg  <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign edge_pulse = edge_reg;

endmodule

// File: rtl/hr_step_sampler.sv
// Sensor front-end: counts conditioned heartbeat and footstep pulses over
// fixed windows and publishes one registered sample per window.
module hr_step_sampler
  import hr_step_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000,
  parameter int DEBOUNCE      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                beat_raw,
  input  logic                step_raw,
  input  logic [STRIDE_W-1:0] stride_cfg,
  output logic [HR_W-1:0]     hr_input,
  output logic [STEPS_W-1:0]  steps_per_second,
  output logic [STRIDE_W-1:0] stride_length,
  output logic                valid_input,
  output logic                hr_warm,
  output logic                step_sat
);

  localparam int TICK_W = $clog2(TICKS_PER_SEC);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

  logic beat_edge;
  logic step_edge;

  pulse_conditioner #(.DEBOUNCE(DEBOUNCE)) u_beat_cond (
    .clk        (clk),
    .rst        (rst),
    .raw        (beat_raw),
    .edge_pulse (beat_edge)
  );

  pulse_conditioner #(.DEBOUNCE(DEBOUNCE)) u_step_cond (
    .clk        (clk),
    .rst        (rst),
    .raw        (step_raw),
    .edge_pulse (step_edge)
  );

  logic [TICK_W-1:0] tick_reg;
  logic [CNT_W-1:0]  beat_cnt_reg;
  logic [CNT_W-1:0]  step_cnt_reg;
  logic [CNT_W-1:0]  hist_reg [HIST_DEPTH];
  logic [1:0]        win_done_reg;
  sample_t           sample_reg;
  logic              valid_reg;
  logic              warm_reg;
  logic              step_sat_reg;

  logic              boundary;
  logic [CNT_W-1:0]  beat_next;
  logic [CNT_W-1:0]  step_next;
  logic [SUM_W-1:0]  hist_sum;
  logic [PROD_W-1:0] bpm_raw;
  sample_t           sample_next;

  // Closing-window counts (including a same-cycle edge) and the sample they form.
  always_comb begin
    boundary  = enable && (tick_reg == TICK_LAST);
    beat_next = sat_inc(beat_cnt_reg, beat_edge && enable);
    step_next = sat_inc(step_cnt_reg, step_edge && enable);
    // Sum of the history as it will be after the shift.
    hist_sum  = SUM_W'(beat_next);
    for (int i = 0; i < HIST_DEPTH - 1; i++)
      hist_sum = hist_sum + SUM_W'(hist_reg[i]);
    bpm_raw = PROD_W'(BPM_SCALE) * PROD_W'(hist_sum);
    sample_next.hr     = (bpm_raw > PROD_W'(BPM_MAX)) ? HR_W'(BPM_MAX) : bpm_raw[HR_W-1:0];
    sample_next.steps  = (step_next > CNT_W'(STEP_MAX)) ? STEPS_W'(STEP_MAX)
                                                        : step_next[STEPS_W-1:0];
    sample_next.stride = stride_cfg;
  end

  // Window counter, pulse counters, history and sample registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_reg     <= '0;
      beat_cnt_reg <= '0;
      step_cnt_reg <= '0;
      for (int i = 0; i < HIST_DEPTH; i++)
        hist_reg[i] <= '0;
      win_done_reg <= '0;
      sample_reg   <= '0;
      valid_reg    <= 1'b0;
      warm_reg     <= 1'b0;
      step_sat_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (boundary) begin
        tick_reg     <= '0;
        hist_reg[0]  <= beat_next;
        for (int i = 1; i < HIST_DEPTH; i++)
          hist_reg[i] <= hist_reg[i-1];
        sample_reg   <= sample_next;
        step_sat_reg <= (step_next > CNT_W'(STEP_MAX));
        valid_reg    <= 1'b1;
        beat_cnt_reg <= '0;
        step_cnt_reg <= '0;
        if (win_done_reg != 2'd3)
          win_done_reg <= win_done_reg + 2'd1;
        else
          warm_reg <= 1'b1;
      end else if (enable) begin
        tick_reg     <= tick_reg + TICK_W'(1);
        beat_cnt_reg <= beat_next;
        step_cnt_reg <= step_next;
      end
    end
  end

  assign hr_input         = sample_reg.hr;
  assign steps_per_second = sample_reg.steps;
  assign stride_length    = sample_reg.stride;
  assign valid_input      = valid_reg;
  assign hr_warm          = warm_reg;
  assign step_sat         = step_sat_reg;

endmodule

// File: tb/tb_hr_step_sampler.sv
// Directed bench for hr_step_sampler with 100-cycle windows and 4-cycle debounce.
module tb_hr_step_sampler;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       beat_raw;
  logic       step_raw;
  logic [7:0] stride_cfg;
  logic [7:0] hr_input;
  logic [1:0] steps_per_second;
  logic [7:0] stride_length;
  logic       valid_input;
  logic       hr_warm;
  logic       step_sat;

  hr_step_sampler #(.TICKS_PER_SEC(100), .DEBOUNCE(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .beat_raw         (beat_raw),
    .step_raw         (step_raw),
    .stride_cfg       (stride_cfg),
    .hr_input         (hr_input),
    .steps_per_second (steps_per_second),
    .stride_length    (stride_length),
    .valid_input      (valid_input),
    .hr_warm          (hr_warm),
    .step_sat         (step_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int nb;        // beats in the window
    int ns;        // steps in the window
    int stride;    // stride_cfg from tick 50 on
    int exp_hr;
    int exp_steps;
    int exp_sat;
    int exp_warm;
  } vec_t;

  vec_t tbl [8];

  int n_pass = 0;
  int n_total = 0;

  // Per-segment stimulus schedule, relative to the segment start.
  int bq[$];
  int bl[$];
  int sq[$];
  int sl[$];
  int en_from;
  int en_len;
  int stride_a;
  int stride_b;
  int stride_sw;
  int strobes[$];
  int mid_hr;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic lvl(input int c, input bit is_step);
    if (is_step) begin
      foreach (sq[i]) if (c >= sq[i] && c < sq[i] + sl[i]) return 1'b1;
    end else begin
      foreach (bq[i]) if (c >= bq[i] && c < bq[i] + bl[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // 0 = no strobe, k>0 = exactly one strobe at offset k, negative = -count.
  function automatic int strobe_sig();
    if (strobes.size() == 0) return 0;
    if (strobes.size() == 1) return strobes[0];
    return -strobes.size();
  endfunction

  task automatic clear_sched(input int stride);
    bq.delete(); bl.delete(); sq.delete(); sl.delete();
    en_from = -1; en_len = 0;
    stride_a = stride; stride_b = stride; stride_sw = 0;
  endtask

  // Drive n cycles from the schedule; record strobe offsets 1..n.
  task automatic run_seg(input int n);
    strobes.delete();
    for (int c = 0; c < n; c++) begin
      if (c == 50) mid_hr = int'(hr_input);
      beat_raw   = lvl(c, 1'b0);
      step_raw   = lvl(c, 1'b1);
      enable     = !(c >= en_from && c < en_from + en_len);
      stride_cfg = 8'((c < stride_sw) ? stride_a : stride_b);
      cyc();
      if (valid_input) strobes.push_back(c + 1);
    end
    beat_raw = 1'b0;
    step_raw = 1'b0;
    enable   = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hr"},     int'(hr_input), 0);
    chk({tag, "_steps"},  int'(steps_per_second), 0);
    chk({tag, "_stride"}, int'(stride_length), 0);
    chk({tag, "_valid"},  int'(valid_input), 0);
    chk({tag, "_warm"},   int'(hr_warm), 0);
    chk({tag, "_sat"},    int'(step_sat), 0);
  endtask

  initial begin
    tbl[0] = '{nb:2, ns:0, stride:40, exp_hr:30,  exp_steps:0, exp_sat:0, exp_warm:0};
    tbl[1] = '{nb:2, ns:5, stride:40, exp_hr:60,  exp_steps:3, exp_sat:1, exp_warm:0};
    tbl[2] = '{nb:2, ns:1, stride:40, exp_hr:90,  exp_steps:1, exp_sat:0, exp_warm:0};
    tbl[3] = '{nb:2, ns:3, stride:75, exp_hr:120, exp_steps:3, exp_sat:0, exp_warm:1};
    tbl[4] = '{nb:2, ns:4, stride:75, exp_hr:120, exp_steps:3, exp_sat:1, exp_warm:1};
    tbl[5] = '{nb:7, ns:7, stride:20, exp_hr:195, exp_steps:3, exp_sat:1, exp_warm:1};
    tbl[6] = '{nb:7, ns:0, stride:20, exp_hr:255, exp_steps:0, exp_sat:0, exp_warm:1};
    tbl[7] = '{nb:0, ns:2, stride:20, exp_hr:240, exp_steps:2, exp_sat:0, exp_warm:1};

    rst = 1'b1; enable = 1'b1; beat_raw = 1'b0; step_raw = 1'b0; stride_cfg = 8'd40;
    mid_hr = 0;
    clear_sched(40);
    cyc(); cyc(); cyc();
    chk_zero("reset");
    rst = 1'b0;

    // Table: one 100-cycle window per record, pulses every 12 cycles.
    for (int w = 0; w < 8; w++) begin
      clear_sched(w == 0 ? 40 : tbl[w-1].stride);
      stride_b  = tbl[w].stride;
      stride_sw = 50;
      for (int k = 0; k < tbl[w].nb; k++) begin bq.push_back(12 * k); bl.push_back(6); end
      for (int k = 0; k < tbl[w].ns; k++) begin sq.push_back(12 * k + 3); sl.push_back(6); end
      run_seg(100);
      chk($sformatf("w%0d_strobe_pos", w), strobe_sig(), 100);
      chk($sformatf("w%0d_hr", w),     int'(hr_input), tbl[w].exp_hr);
      chk($sformatf("w%0d_steps", w),  int'(steps_per_second), tbl[w].exp_steps);
      chk($sformatf("w%0d_sat", w),    int'(step_sat), tbl[w].exp_sat);
      chk($sformatf("w%0d_stride", w), int'(stride_length), tbl[w].stride);
      chk($sformatf("w%0d_warm", w),   int'(hr_warm), tbl[w].exp_warm);
      if (w > 0) chk($sformatf("w%0d_hold_hr", w), mid_hr, tbl[w-1].exp_hr);
      $display("window %0d: hr=%0d steps=%0d sat=%0d stride=%0d warm=%0d",
               w, hr_input, steps_per_second, step_sat, stride_length, hr_warm);
    end

    // Reset at tick 60 after three beats: partial window discarded.
    clear_sched(20);
    bq = '{5, 20, 35}; bl = '{6, 6, 6};
    run_seg(60);
    chk("midrst_no_strobe", strobe_sig(), 0);
    rst = 1'b1;
    cyc();
    chk_zero("midrst");
    rst = 1'b0;
    clear_sched(20);
    bq = '{10, 40}; bl = '{6, 6};
    run_seg(100);
    chk("postrst_strobe_pos", strobe_sig(), 100);
    chk("postrst_hr", int'(hr_input), 30);
    chk("postrst_warm", int'(hr_warm), 0);
    chk("postrst_stride", int'(stride_length), 20);
    $display("post-reset window: hr=%0d warm=%0d", hr_input, hr_warm);

    // Enable low for 30 cycles mid-window; the beat inside it is dropped.
    clear_sched(20);
    bq = '{10, 45, 80}; bl = '{6, 6, 6};
    en_from = 40; en_len = 30;
    run_seg(130);
    chk("enlow_strobe_pos", strobe_sig(), 130);
    chk("enlow_hr", int'(hr_input), 60);
    $display("enable-gap window: hr=%0d strobe_at=%0d", hr_input, strobe_sig());

    // Enable dropped exactly on the boundary cycle: boundary slips one cycle.
    clear_sched(20);
    en_from = 99; en_len = 1;
    run_seg(101);
    chk("bnd_en_strobe_pos", strobe_sig(), 101);
    chk("bnd_en_hr", int'(hr_input), 60);
    $display("boundary-enable window: hr=%0d strobe_at=%0d", hr_input, strobe_sig());

    // Fresh reset; glitch rejection and edge latency at the window edge.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    clear_sched(9);
    bq = '{10, 93}; bl = '{3, 4};   // 3-cycle glitch, then edge lands on tick 99
    sq = '{94}; sl = '{4};          // edge lands on tick 0 of the next window
    run_seg(100);
    chk("edge_w1_strobe_pos", strobe_sig(), 100);
    chk("edge_w1_hr", int'(hr_input), 15);
    chk("edge_w1_steps", int'(steps_per_second), 0);
    $display("edge window 1: hr=%0d steps=%0d", hr_input, steps_per_second);
    clear_sched(9);
    run_seg(100);
    chk("edge_w2_strobe_pos", strobe_sig(), 100);
    chk("edge_w2_hr", int'(hr_input), 15);
    chk("edge_w2_steps", int'(steps_per_second), 1);
    chk("edge_w2_sat", int'(step_sat), 0);
    $display("edge window 2: hr=%0d steps=%0d", hr_input, steps_per_second);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hr_step_sampler.md
# hr_step_sampler

Sensor front-end for the fitness datapath. Conditions raw heartbeat and footstep pulses, counts them over fixed one-second windows and, once per window, presents a registered sample (`hr_input`, `steps_per_second`, `stride_length`) with a one-cycle `valid_input` strobe. These outputs drive the step-calculator stage directly. Heart rate is a rolling 4-second estimate in BPM.

## Interface
- `TICKS_PER_SEC`, 1000: clock cycles per sample window; ≥ 8.
- `DEBOUNCE`, 4: cycles a synchronized input must hold a new level before it is accepted; ≥ 1.

- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous reset, active-high.
- `enable`  in  1  high = windows run; low = window counter and pulse counts freeze.
- `beat_raw`  in  1  asynchronous heartbeat sensor level; one rising edge per beat.
- `step_raw`  in  1  asynchronous footstep sensor level; one rising edge per step.
- `stride_cfg`  in  8  user stride length; sampled at the window boundary.
- `hr_input`  out  8  estimated BPM, saturated at 255.
- `steps_per_second`  out  2  steps in the last window, saturated at 3.
- `stride_length`  out  8  `stride_cfg` latched at the window boundary.
- `valid_input`  out  1  one-cycle strobe: the sample outputs are new.
- `hr_warm`  out  1  high once 4 windows have completed since reset.
- `step_sat`  out  1  high with the sample if the raw step count exceeded 3.

## Operation
- **Conditioning (per input):**
  - 2-flop synchronizer, then debounce.
  - The debounced level changes only after the synchronized value has differed from it for `DEBOUNCE` consecutive cycles.
  - A rising edge of the debounced level produces a one-cycle `edge` pulse.
  - Conditioning runs regardless of `enable`.
- **Window counter:**
  - `tick` counts 0..`TICKS_PER_SEC`-1 while `enable` is high, then wraps to 0.
  - The boundary cycle is `tick==TICKS_PER_SEC-1` with `enable` high.
- **Counting:**
  - `beat_cnt` is 3 bits, saturating at 7.
  - `step_cnt` is 3 bits, saturating at 7.
  - Each increments on its `edge` while `enable` is high.
  - An edge in the boundary cycle is counted in the closing window.
- **At the boundary cycle, all updates register together:**
  - History: shift register `hist[0..3]` of 3-bit per-window beat counts; `hist[0]` ← `beat_cnt` including any same-cycle edge.
  - `hr_input` ← min(255, 15 × (sum of the new `hist[0..3]`)). The sum is 5 bits; the product is 9 bits before saturation.
  - `steps_per_second` ← min(3, step total).
  - `step_sat` ← (step total > 3).
  - `stride_length` ← `stride_cfg`.
  - `beat_cnt` and `step_cnt` clear to 0.
  - `win_done` (2-bit, saturating at 3) increments.
- **Warm-up:**
  - `hr_warm` ← 1 at the boundary where `win_done` is already 3, i.e. the 4th sample. It stays high until reset.
  - Samples before warm-up are still emitted, using zeros in `hist`.
- **`enable` low:**
  - `tick`, the counts and `hist` hold.
  - Edges are dropped.
  - No strobe is produced.
- **Reset:** every register clears to 0, including all outputs, `hist`, the synchronizers and the debounced levels. Reset has priority over every other event.

## Timing
- Sample outputs and `valid_input` are registered and change in the cycle after the boundary cycle.
- `valid_input` is high for exactly one cycle per window; strobes are `TICKS_PER_SEC` cycles apart while enabled.
- Sample outputs hold their values between strobes.
- Raw edge to `edge` pulse: 2 (synchronizer) + `DEBOUNCE` cycles.
- First strobe after reset (enable held high): cycle `TICKS_PER_SEC` after reset is released.
- Reset asserted mid-window: the partial window is discarded and no strobe is produced.
- `enable` deasserted on the boundary cycle: the boundary is not taken. It is taken on the next enabled cycle with `tick==TICKS_PER_SEC-1`.

## Structure
- Package `hr_step_pkg`:
  - `BPM_SCALE` = 15, `HIST_DEPTH` = 4.
  - `CNT_W` = 3, `STEP_MAX` = 3, `BPM_MAX` = 255.
  - Sample struct: `hr`, `steps`, `stride`.
- Sub-module `pulse_conditioner` (synchronizer + debounce + rising-edge detect, parameter `DEBOUNCE`), instantiated once for beats and once for steps.
- Top level holds the window counter, counters, history and output registers.

## Test plan
All scenarios use `TICKS_PER_SEC`=100 and `DEBOUNCE`=4.
- 2 clean beats per window for 5 windows:
  - `hr_input` = 30, 60, 90, 120, 120.
  - `hr_warm` rises with the 4th strobe.
  - Strobes are 100 cycles apart.
- 5 steps in one window → `steps_per_second`=3 and `step_sat`=1; next window with 1 step → 1, 0.
- 3-cycle glitch on `beat_raw` → no count. 4-cycle pulse → counted, with the edge 6 cycles after the raw edge.
- Step edge arriving so its `edge` pulse lands on `tick`=99 → counted in the closing sample. At `tick`=0 → counted in the next sample.
- `stride_cfg` changes 40→75 at `tick`=50 → `stride_length` reads 75 at that window's strobe, and 40 at the previous strobe.
- `rst` pulsed at `tick`=60 after 3 beats → all outputs are 0 and no strobe. The first strobe comes 100 cycles after release, with `hr_input` = 15 × (beats since release).
- `enable` low for 30 cycles mid-window → strobe is delayed by 30 cycles, and edges during the low period are not counted.
